// File: rtl/integ_dump_ctrl_pkg.sv
// Shared decimator definitions: rate width, headroom, controller states and
// the bit-gain table every integrate-and-dump stage scales by.
package integ_dump_ctrl_pkg;

    localparam int RATE_W      = 8;
    localparam int MAX_BITGAIN = 8;

    typedef enum logic {IDLE, INTEG} state_t;

    // ceil(log2(r+1)) clamped to 1..8
    function automatic logic [3:0] bitgain(input logic [RATE_W-1:0] r);
        logic [RATE_W:0] n;
        logic [3:0]      g;
        n = (RATE_W+1)'(r) + (RATE_W+1)'(1);
        g = 4'd1;
        for (int i = 1; i < RATE_W; i++)
            if (((RATE_W+1)'(1) << i) < n) g = 4'(i + 1);
        return g;
    endfunction

endpackage

// File: rtl/integ_dump_ctrl_if.sv
// Sample-stream bundle between the strobe source, the decimator and its consumer.
interface integ_dump_ctrl_if
    import integ_dump_ctrl_pkg::*;
#(
    parameter int bw = 16
);
    logic                 enable;
    logic [RATE_W-1:0]    rate;
    logic                 strobe_in;
    logic signed [bw-1:0] signal_in;
    logic                 strobe_out;
    logic signed [bw-1:0] signal_out;

    modport master (output enable, rate, strobe_in, signal_in,
                    input  strobe_out, signal_out);
    modport slave  (input  enable, rate, strobe_in, signal_in,
                    output strobe_out, signal_out);
endinterface

// File: rtl/integ_dump_ctrl_shifter.sv
// Integrator bit-gain shifter: drops the window's gain bits from the sum,
// truncating toward minus infinity.
module integ_shifter
    import integ_dump_ctrl_pkg::*;
#(
    parameter int bw         = 16,
    parameter int maxbitgain = MAX_BITGAIN
) (
    input  logic signed [bw+maxbitgain-1:0] sum,
    input  logic        [RATE_W-1:0]        rate,
    output logic signed [bw-1:0]            scaled
);
    logic [3:0] shift;

    assign shift  = bitgain(rate);
    assign scaled = bw'(sum >>> shift);
endmodule

// File: rtl/integ_dump_ctrl.sv
// Integrate-and-dump decimation controller: sums rate+1 strobed samples and
// emits one scaled output sample with a single-cycle strobe.
module integ_dump_ctrl
    import integ_dump_ctrl_pkg::*;
#(
    parameter int bw         = 16,
    parameter int maxbitgain = MAX_BITGAIN
) (
    input  logic             clock,
    input  logic             reset,
    integ_dump_ctrl_if.slave bus
);
    localparam int AW = bw + maxbitgain;

    state_t               state, state_nxt;
    logic                 flush;
    logic [RATE_W-1:0]    count, rate_r, rate_eff;
    logic signed [AW-1:0] acc, ext, sum;
    logic signed [bw-1:0] scaled, out_q;
    logic                 strobe_q, terminal;

    // Sample taken on the enable-rise cycle is window sample 0, so flushing
    // follows enable directly rather than the registered state.
    always_comb begin
        state_nxt = state;
        flush     = !bus.enable;
        case (state)
            IDLE:    if (bus.enable)  state_nxt = INTEG;
            INTEG:   if (!bus.enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ext      = {{maxbitgain{bus.signal_in[bw-1]}}, bus.signal_in};
    assign sum      = ((count == '0) ? AW'(0) : acc) + ext;
    assign rate_eff = (count == '0) ? bus.rate : rate_r;
    assign terminal = (count == rate_eff);

    integ_shifter #(.bw(bw), .maxbitgain(maxbitgain)) u_shift (
        .sum    (sum),
        .rate   (rate_eff),
        .scaled (scaled)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            rate_r   <= '0;
            strobe_q <= 1'b0;
            out_q    <= '0;
        end else begin
            state    <= state_nxt;
            strobe_q <= 1'b0;
            if (flush) begin
                count <= '0;
                acc   <= '0;
            end else if (bus.strobe_in) begin
                acc <= sum;
                if (count == '0) rate_r <= bus.rate;
                if (terminal) begin
                    count    <= '0;
                    out_q    <= scaled;
                    strobe_q <= 1'b1;
                end else begin
                    count <= count + 8'd1;
                end
            end
        end
    end

    assign bus.strobe_out = strobe_q;
    assign bus.signal_out = out_q;
endmodule

// File: tb/tb_integ_dump_ctrl.sv
// Self-checking bench for integ_dump_ctrl: vector table, directed corner
// sequences and a randomized run against a window-queue reference model.
module tb_integ_dump_ctrl;
    import integ_dump_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    integ_dump_ctrl_if #(.bw(16)) bus ();

    integ_dump_ctrl #(.bw(16), .maxbitgain(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model: the open window is just a list of its samples
    int                 win[$];
    int                 wrate;
    logic               m_so;
    logic signed [15:0] m_out;

    typedef struct {
        logic               rst, en;
        logic [7:0]         rt;
        logic               stb;
        logic signed [15:0] d;
        logic               eso;
        logic signed [15:0] eout;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic rst, en, input logic [7:0] rt, input logic stb,
                       input int d, input logic eso, input int eout);
        vec_t v;
        v.rst = rst; v.en = en; v.rt = rt; v.stb = stb;
        v.d = 16'(d); v.eso = eso; v.eout = 16'(eout);
        tbl.push_back(v);
    endtask

    task automatic model_edge();
        longint s;
        int     sh;
        if (reset) begin
            win.delete(); wrate = 0; m_so = 1'b0; m_out = '0;
        end else begin
            m_so = 1'b0;
            if (!bus.enable) win.delete();
            else if (bus.strobe_in) begin
                if (win.size() == 0) wrate = int'(bus.rate);
                win.push_back(int'(bus.signal_in));
                if (win.size() == wrate + 1) begin
                    s = 0;
                    foreach (win[i]) s += win[i];
                    sh = $clog2(wrate + 1);
                    if (sh < 1) sh = 1;
                    m_out = 16'(s >>> sh);
                    m_so  = 1'b1;
                    win.delete();
                end
            end
        end
    endtask

    task automatic check(input string name, input logic eso, input logic signed [15:0] eout);
        total++;
        if (bus.strobe_out !== eso || bus.signal_out !== eout) begin
            bad++;
            $display("FAIL %s: got strobe_out=%b signal_out=%0d, want strobe_out=%b signal_out=%0d",
                     name, bus.strobe_out, bus.signal_out, eso, eout);
        end
    endtask

    // one clock: apply inputs, advance model at the edge, compare on the falling edge
    task automatic step(input string name, input logic rst, en, input logic [7:0] rt,
                        input logic stb, input int d);
        reset = rst; bus.enable = en; bus.rate = rt; bus.strobe_in = stb;
        bus.signal_in = 16'(d);
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check(name, m_so, m_out);
    endtask

    initial begin
        // rate 0 pair, rate 3 spaced window, enable flush and re-entry
        add(1, 0, 0, 0,    0, 0,    0);
        add(0, 1, 0, 1,  100, 1,   50);
        add(0, 1, 0, 1, -100, 1,  -50);
        add(0, 1, 0, 0,    0, 0,  -50);
        for (int k = 0; k < 4; k++) begin
            add(0, 1, 3, 1, 1000, (k == 3), (k == 3) ? 1000 : -50);
            if (k < 3) begin
                add(0, 1, 3, 0, 0, 0, -50);
                add(0, 1, 3, 0, 0, 0, -50);
            end
        end
        add(0, 1, 3, 0, 0, 0, 1000);
        add(0, 1, 3, 1, 8, 0, 1000);
        add(0, 1, 3, 1, 8, 0, 1000);
        add(0, 0, 3, 1, 8, 0, 1000);
        add(0, 1, 3, 1, 8, 0, 1000);
        add(0, 1, 3, 1, 8, 0, 1000);
        add(0, 1, 3, 1, 8, 0, 1000);
        add(0, 1, 3, 1, 8, 1,    8);
        add(0, 1, 3, 0, 0, 0,    8);

        foreach (tbl[i]) begin
            step($sformatf("vec%0d_model", i), tbl[i].rst, tbl[i].en, tbl[i].rt,
                 tbl[i].stb, int'(tbl[i].d));
            check($sformatf("vec%0d", i), tbl[i].eso, tbl[i].eout);
        end

        // full-scale 256-sample windows must not wrap
        for (int i = 0; i < 256; i++) step("fs_pos", 0, 1, 255, 1, 32767);
        check("fs_pos_dump", 1'b1, 16'sd32767);
        for (int i = 0; i < 256; i++) step("fs_neg", 0, 1, 255, 1, -32768);
        check("fs_neg_dump", 1'b1, -16'sd32768);

        // rate change mid-window only takes effect at the next window
        step("rc", 0, 1, 4, 1, 800);
        step("rc", 0, 1, 4, 1, 800);
        step("rc", 0, 1, 0, 1, 800);
        step("rc", 0, 1, 0, 1, 800);
        step("rc", 0, 1, 0, 1, 800);
        check("rc_dump", 1'b1, 16'sd500);
        step("rc", 0, 1, 0, 1, 800);
        check("rc_per_sample", 1'b1, 16'sd400);

        // enable low on the terminal sample drops it
        step("term_drop", 0, 1, 1, 1, 20);
        step("term_drop", 0, 0, 1, 1, 20);
        check("term_drop_none", 1'b0, 16'sd400);

        // reset mid-window with enable and strobe still high
        step("rst_mid", 0, 1, 3, 1, 77);
        step("rst_mid", 0, 1, 3, 1, 77);
        step("rst_mid", 1, 1, 3, 1, 77);
        check("rst_mid_out", 1'b0, 16'sd0);
        step("rst_after", 0, 1, 0, 1, 6);
        check("rst_after_fresh", 1'b1, 16'sd3);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic       r_rst, r_en, r_stb;
            logic [7:0] r_rt;
            int         pick;
            r_rst = ($urandom_range(199) == 0);
            r_en  = ($urandom_range(19) != 0);
            r_stb = ($urandom_range(9) < 6);
            pick  = $urandom_range(5);
            r_rt  = (pick == 5) ? 8'($urandom_range(255)) : 8'(pick);
            step("rand", r_rst, r_en, r_rt, r_stb, int'($signed(16'($urandom))));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
